// File: rtl/apo_noc_pkg.sv
// Shared definitions for the APO circulant-ring router: port indices,
// flit field helpers and the minimal-offset routing rule.
package apo_noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int FLIT_MAX_W = 64;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_R1    = 3'd1;
  localparam logic [2:0] PORT_R2    = 3'd2;
  localparam logic [2:0] PORT_L1    = 3'd3;
  localparam logic [2:0] PORT_L2    = 3'd4;

  // Callers zero-extend their flit to FLIT_MAX_W; flit = {dst, payload}.
  function automatic int flit_dst(input logic [FLIT_MAX_W-1:0] flit,
                                  input int data_w, input int addr_w);
    logic [FLIT_MAX_W-1:0] w_mask;
    w_mask = (FLIT_MAX_W'(1) << addr_w) - FLIT_MAX_W'(1);
    return int'(32'((flit >> data_w) & w_mask));
  endfunction

  function automatic logic [FLIT_MAX_W-1:0] flit_payload(input logic [FLIT_MAX_W-1:0] flit,
                                                         input int data_w);
    return flit & ((FLIT_MAX_W'(1) << data_w) - FLIT_MAX_W'(1));
  endfunction

  // Clockwise distance picks the direction; the long hop is taken whenever
  // the remaining distance covers it, otherwise the short hop.
  function automatic logic [2:0] route_port(input int dst, input int me,
                                            input int n, input int s2);
    int d;
    int e;
    d = (dst - me + n) % n;
    if (d == 0) return PORT_LOCAL;
    if (d <= n / 2) return (d >= s2) ? PORT_R2 : PORT_R1;
    e = n - d;
    return (e >= s2) ? PORT_L2 : PORT_L1;
  endfunction

endpackage

// File: rtl/apo_flit_fifo.sv
// Per-input flit FIFO with a combinational head so routing sees the
// oldest flit in the same cycle it becomes visible.
module apo_flit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en && !o_full)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en && !o_full) r_mem[r_wr_ptr[PW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[PW-1:0]];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/apo_router_param.sv
// Five-port router node for a circulant ring C_N(S1,S2): input FIFOs,
// per-output round-robin arbitration and one-flit output registers.
module apo_router_param
  import apo_noc_pkg::*;
#(
  parameter  int N      = 16,
  parameter  int S1     = 2,
  parameter  int S2     = 3,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(N),
  localparam int FLIT_W = ADDR_W + DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           router_name,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [7:0]                  drop_count
);

  if (!(S1 > 0 && S1 < S2 && S2 <= N / 2 && DEPTH >= 2 &&
        (DEPTH & (DEPTH - 1)) == 0)) begin : g_bad_cfg
    $error("apo_router_param: invalid generator offsets or FIFO depth");
  end

  logic                               r_ready_en;
  logic [7:0]                         r_drop_count;
  logic [NUM_PORTS-1:0]               w_empty;
  logic [NUM_PORTS-1:0]               w_full;
  logic [NUM_PORTS-1:0]               w_pop;
  logic [NUM_PORTS-1:0]               w_drop;
  logic [NUM_PORTS-1:0]               w_wr_en;
  logic [NUM_PORTS*FLIT_W-1:0]        w_head;
  logic [NUM_PORTS*NUM_PORTS-1:0]     w_req;  // bit in*5+out
  logic [NUM_PORTS*NUM_PORTS-1:0]     w_gnt;  // bit out*5+in
  logic [2:0]                         w_drops;
  logic [8:0]                         w_drop_sum;

  assign in_ready = {NUM_PORTS{r_ready_en}} & ~w_full;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    logic [FLIT_W-1:0] w_flit;
    logic [2:0]        w_route;
    logic              w_granted;

    assign w_wr_en[gi] = in_valid[gi] & in_ready[gi];

    apo_flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en[gi]),
      .i_wr_data (in_flit[gi*FLIT_W +: FLIT_W]),
      .i_rd_en   (w_pop[gi]),
      .o_rd_data (w_flit),
      .o_empty   (w_empty[gi]),
      .o_full    (w_full[gi])
    );

    assign w_head[gi*FLIT_W +: FLIT_W] = w_flit;
    assign w_drop[gi]  = !w_empty[gi] &&
                         (flit_dst(FLIT_MAX_W'(w_flit), DATA_W, ADDR_W) >= N);
    assign w_route     = route_port(flit_dst(FLIT_MAX_W'(w_flit), DATA_W, ADDR_W),
                                    32'(router_name), N, S2);
    assign w_req[gi*NUM_PORTS +: NUM_PORTS] =
      (!w_empty[gi] && !w_drop[gi]) ? (NUM_PORTS'(1) << w_route) : '0;

    always_comb begin
      w_granted = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) w_granted = w_granted | w_gnt[k*NUM_PORTS + gi];
    end

    // Unroutable heads leave without needing any output slot.
    assign w_pop[gi] = w_drop[gi] | w_granted;
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
    logic [NUM_PORTS-1:0] w_req_col;
    logic [NUM_PORTS-1:0] w_rot;
    logic [2:0]           w_off;
    logic [2:0]           w_win;
    logic [3:0]           w_sum;
    logic                 w_any;
    logic                 w_load_ok;
    logic                 w_fire;
    logic [FLIT_W-1:0]    w_sel;
    logic [2:0]           r_prio;
    logic                 r_valid;
    logic [FLIT_W-1:0]    r_flit;

    always_comb begin
      w_req_col = '0;
      for (int k = 0; k < NUM_PORTS; k++) w_req_col[k] = w_req[k*NUM_PORTS + gi];
    end

    // Rotate so bit 0 is the current highest-priority input.
    assign w_rot = NUM_PORTS'({w_req_col, w_req_col} >> r_prio);
    assign w_any = |w_rot;

    always_comb begin
      w_off = 3'd0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (w_rot[k]) w_off = 3'(k);
      end
    end

    assign w_sum     = {1'b0, r_prio} + {1'b0, w_off};
    assign w_win     = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
    assign w_load_ok = !r_valid || out_ready[gi];
    assign w_fire    = w_any && w_load_ok;
    assign w_gnt[gi*NUM_PORTS +: NUM_PORTS] = w_fire ? (NUM_PORTS'(1) << w_win) : '0;

    always_comb begin
      w_sel = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (w_win == 3'(k)) w_sel = w_head[k*FLIT_W +: FLIT_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prio  <= 3'd0;
        r_valid <= 1'b0;
        r_flit  <= '0;
      end else if (w_fire) begin
        r_valid <= 1'b1;
        r_flit  <= w_sel;
        r_prio  <= (w_win == 3'd4) ? 3'd0 : w_win + 3'd1;
      end else if (out_ready[gi]) begin
        r_valid <= 1'b0;
      end
    end

    assign out_valid[gi]                  = r_valid;
    assign out_flit[gi*FLIT_W +: FLIT_W] = r_flit;
  end

  always_comb begin
    w_drops = 3'd0;
    for (int k = 0; k < NUM_PORTS; k++) w_drops = w_drops + {2'b00, w_drop[k]};
  end

  assign w_drop_sum = {1'b0, r_drop_count} + {6'b0, w_drops};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_ready_en   <= 1'b1;
      r_drop_count <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_apo_router_param.sv
// Bench for apo_router_param: routing table, arbitration, backpressure,
// drop/reset corners and a randomized scoreboard run on an N=12 ring.
module tb_apo_router_param;

  localparam int FW = 12;

  logic          clk;
  logic          rst_n;
  logic [3:0]    rn16, rn12;
  logic [5*FW-1:0] if16, if12, of16, of12;
  logic [4:0]    iv16, ir16, ov16, or16;
  logic [4:0]    iv12, ir12, ov12, or12;
  logic [7:0]    dc16, dc12;

  int n_pass;
  int n_total;

  typedef struct {
    int dst;
    int pay;
    int port;
  } vec_t;

  vec_t tbl [11];
  logic [11:0] exp_q [25][$];
  int seq [5];
  int exp_drops;

  apo_router_param u16 (
    .clk(clk), .rst_n(rst_n), .router_name(rn16),
    .in_flit(if16), .in_valid(iv16), .in_ready(ir16),
    .out_flit(of16), .out_valid(ov16), .out_ready(or16),
    .drop_count(dc16)
  );

  apo_router_param #(.N(12)) u12 (
    .clk(clk), .rst_n(rst_n), .router_name(rn12),
    .in_flit(if12), .in_valid(iv12), .in_ready(ir12),
    .out_flit(of12), .out_valid(ov12), .out_ready(or12),
    .drop_count(dc12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    iv16 = '0;
    iv12 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [11:0] mk(input int dst, input int pay);
    return {4'(dst), 8'(pay)};
  endfunction

  function automatic logic [11:0] slice(input logic [5*FW-1:0] v, input int p);
    return v[p*FW +: FW];
  endfunction

  // Shortest-direction rule on the ring, long hop when the distance allows it.
  function automatic int ref_route(input int dst, input int me, input int n, input int s2);
    int d;
    d = ((dst - me) % n + n) % n;
    if (d == 0) return 0;
    if (2 * d <= n) return (d >= s2) ? 2 : 1;
    return (n - d >= s2) ? 4 : 3;
  endfunction

  initial begin
    int acc;
    int src;
    int left;
    logic [11:0] f;
    logic [4:0] fire;
    logic fire0;

    n_pass = 0;
    n_total = 0;
    exp_drops = 0;
    for (int p = 0; p < 5; p++) seq[p] = 0;

    tbl[0]  = '{0,  'hA5, 0};
    tbl[1]  = '{5,  'h11, 2};
    tbl[2]  = '{1,  'h22, 1};
    tbl[3]  = '{14, 'h33, 3};
    tbl[4]  = '{12, 'h44, 4};
    tbl[5]  = '{2,  'h55, 1};
    tbl[6]  = '{3,  'h66, 2};
    tbl[7]  = '{8,  'h77, 2};
    tbl[8]  = '{9,  'h88, 4};
    tbl[9]  = '{15, 'h99, 3};
    tbl[10] = '{13, 'hAA, 4};

    rst_n = 1'b1;
    rn16 = 4'd0; rn12 = 4'd0;
    if16 = '0; if12 = '0; iv16 = '0; iv12 = '0;
    or16 = '1; or12 = '1;
    #1 rst_n = 1'b0;

    @(negedge clk);
    chk("rst_in_ready",   32'(ir16), 32'(0));
    chk("rst_out_valid",  32'(ov16), 32'(0));
    chk("rst_out_flit",   32'(of16 != '0), 32'(0));
    chk("rst_drop_count", 32'(dc16), 32'(0));
    tick();
    rst_n = 1'b1;
    #1 chk("rst_ready_held", 32'(ir16), 32'(0));
    tick();
    chk("rst_ready_rise", 32'(ir16), 32'h1f);

    // Routing table on local input: one-cycle FIFO residency, then exit port.
    for (int i = 0; i < 11; i++) begin
      if16[FW-1:0] = mk(tbl[i].dst, tbl[i].pay);
      iv16[0] = 1'b1;
      tick();
      iv16[0] = 1'b0;
      chk($sformatf("lat_idle_%0d", i), 32'(ov16), 32'(0));
      tick();
      chk($sformatf("route_valid_%0d", i), 32'(ov16), 32'(1) << tbl[i].port);
      chk($sformatf("route_flit_%0d", i), 32'(slice(of16, tbl[i].port)),
          32'(mk(tbl[i].dst, tbl[i].pay)));
      $display("vec %0d dst=%0d payload=0x%0h expect port %0d", i, tbl[i].dst, tbl[i].pay, tbl[i].port);
      tick();
    end

    // Contention on output 0: reset priority picks 1, then rotation lets 2
    // beat port 1's follow-up flit.
    do_reset();
    or16 = '1;
    if16[1*FW +: FW] = mk(0, 'h21);
    if16[2*FW +: FW] = mk(0, 'h32);
    iv16 = 5'b00110;
    tick();
    iv16[2] = 1'b0;
    if16[1*FW +: FW] = mk(0, 'h23);
    chk("arb_idle", 32'(ov16), 32'(0));
    tick();
    iv16[1] = 1'b0;
    chk("arb_first",  32'({ov16[0], slice(of16, 0)}), 32'({1'b1, mk(0, 'h21)}));
    $display("arb grant 1: flit 0x%0h", slice(of16, 0));
    tick();
    chk("arb_second", 32'({ov16[0], slice(of16, 0)}), 32'({1'b1, mk(0, 'h32)}));
    $display("arb grant 2: flit 0x%0h", slice(of16, 0));
    tick();
    chk("arb_third",  32'({ov16[0], slice(of16, 0)}), 32'({1'b1, mk(0, 'h23)}));
    $display("arb grant 3: flit 0x%0h", slice(of16, 0));
    tick();
    chk("arb_done", 32'(ov16), 32'(0));

    // Backpressure on port 2: register plus DEPTH FIFO entries fill up.
    or16 = 5'b11011;
    acc = 0;
    if16[FW-1:0] = mk(5, 0);
    iv16[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      fire0 = ir16[0];
      tick();
      if (fire0) begin
        acc++;
        if16[FW-1:0] = mk(5, acc);
      end
    end
    chk("bp_accepted", 32'(acc), 32'(5));
    chk("bp_in_ready", 32'(ir16[0]), 32'(0));
    or16 = '1;
    for (int j = 0; j < 6; j++) begin
      fire0 = iv16[0] & ir16[0];
      chk($sformatf("bp_drain_%0d", j), 32'({ov16[2], slice(of16, 2)}), 32'({1'b1, mk(5, j)}));
      $display("bp deliver %0d: flit 0x%0h", j, slice(of16, 2));
      tick();
      if (fire0) iv16[0] = 1'b0;
    end
    chk("bp_empty", 32'(ov16), 32'(0));

    // N=12: destination 13 is unroutable and must be discarded.
    or12 = '1;
    if12[FW-1:0] = mk(13, 'h77);
    iv12[0] = 1'b1;
    tick();
    iv12[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("drop_no_out_%0d", c), 32'(ov12), 32'(0));
      tick();
    end
    chk("drop_count_one", 32'(dc12), 32'(1));
    $display("drop dst=13: drop_count=%0d", dc12);

    // Asynchronous reset with three flits buffered.
    or12 = '0;
    for (int c = 0; c < 3; c++) begin
      if12[FW-1:0] = mk(0, 'h40 + c);
      iv12[0] = 1'b1;
      tick();
    end
    iv12[0] = 1'b0;
    chk("buffered_before_rst", 32'(ov12[0]), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid",  32'(ov12), 32'(0));
    chk("arst_out_flit",   32'(of12 != '0), 32'(0));
    chk("arst_drop_count", 32'(dc12), 32'(0));
    chk("arst_in_ready",   32'(ir12), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    or12 = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("no_stale_%0d", c), 32'(ov12), 32'(0));
    end

    // Randomized traffic on the N=12 ring from node 7.
    rn12 = 4'd7;
    do_reset();
    for (int cyc = 0; cyc < 440; cyc++) begin
      fire = '0;
      for (int p = 0; p < 5; p++) begin
        if (cyc < 400 && !iv12[p] && $urandom_range(0, 1) == 1) begin
          if12[p*FW +: FW] = mk(int'($urandom_range(0, 15)), p * 32 + (seq[p] % 32));
          iv12[p] = 1'b1;
          seq[p]++;
        end
        if (iv12[p] && ir12[p]) begin
          fire[p] = 1'b1;
          f = if12[p*FW +: FW];
          if (int'(f[11:8]) >= 12) exp_drops++;
          else exp_q[p*5 + ref_route(int'(f[11:8]), 7, 12, 3)].push_back(f);
        end
      end
      or12 = (cyc < 400) ? (5'($urandom) | 5'($urandom)) : 5'h1f;
      for (int o = 0; o < 5; o++) begin
        if (ov12[o] && or12[o]) begin
          f = slice(of12, o);
          src = int'(f[7:5]);
          if (src > 4 || exp_q[src*5 + o].size() == 0) begin
            n_total++;
            $display("FAIL rand_deliv: port %0d got unexpected flit 0x%0h", o, f);
          end else begin
            chk($sformatf("rand_deliv_p%0d", o), 32'(f), 32'(exp_q[src*5 + o].pop_front()));
          end
        end
      end
      tick();
      for (int p = 0; p < 5; p++) if (fire[p]) iv12[p] = 1'b0;
    end
    left = 0;
    for (int q = 0; q < 25; q++) left += exp_q[q].size();
    chk("rand_all_delivered", 32'(left), 32'(0));
    chk("rand_drop_count", 32'(dc12), 32'((exp_drops > 255) ? 255 : exp_drops));
    $display("random run: %0d drops expected", exp_drops);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
